// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce_pulse input-conditioning stage.
package debounce_pkg;

  // Stable levels and the two qualifying (counting) states between them.
  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_t;

  localparam int unsigned StableCyclesDefault = 1000;
  localparam int unsigned CntWDefault         = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic q_sync
);

  logic sync1_q;
  logic sync2_q;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= d_async;
      sync2_q <= sync1_q;
    end
  end

  assign q_sync = sync2_q;

endmodule

// File: rtl/debounce_pulse.sv
// Debounces a raw bouncy input into a stable level plus one-cycle rise/fall strobes.
// A new level is accepted only after STABLE_CYCLES consecutive synchronised samples.
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = StableCyclesDefault,
  parameter int unsigned CNT_W         = CntWDefault
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  // Count value on which the final qualifying sample completes the transition.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

  logic             sync2;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_2ff u_sync (
    .clk     (clk),
    .reset   (reset),
    .d_async (din),
    .q_sync  (sync2)
  );

  // Next-state, stability counter and strobe decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_LOW: begin
        if (sync2) begin
          if (STABLE_CYCLES == 1) begin
            state_d = S_HIGH;
            cnt_d   = '0;
          end else begin
            state_d = S_WAIT_HIGH;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      S_WAIT_HIGH: begin
        if (!sync2) begin
          // Bounce: no partial credit, restart from the stable low state.
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (!sync2) begin
          if (STABLE_CYCLES == 1) begin
            state_d = S_LOW;
            cnt_d   = '0;
          end else begin
            state_d = S_WAIT_LOW;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      S_WAIT_LOW: begin
        if (sync2) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    // Strobes only on real level changes, not on glitch returns to the same level.
    rise_d = (state_d == S_HIGH) && ((state_q == S_LOW) || (state_q == S_WAIT_HIGH));
    fall_d = (state_d == S_LOW)  && ((state_q == S_HIGH) || (state_q == S_WAIT_LOW));
  end

  // State, counter and strobe registers; reset kills any in-flight strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign dout = (state_q == S_HIGH) || (state_q == S_WAIT_LOW);
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed bench for debounce_pulse with STABLE_CYCLES=4, CNT_W=4.
module tb_debounce_pulse;

  logic clk;
  logic reset;
  logic din;
  logic dout;
  logic rise;
  logic fall;

  int n_tests;
  int n_fail;

  debounce_pulse #(
    .STABLE_CYCLES (4),
    .CNT_W         (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .dout  (dout),
    .rise  (rise),
    .fall  (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_dout, input logic e_rise,
                            input logic e_fall);
    check_eq({tag, ".dout"}, dout, e_dout);
    check_eq({tag, ".rise"}, rise, e_rise);
    check_eq({tag, ".fall"}, fall, e_fall);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // din has just changed; e counts edges from 0. Level and strobe move after edge 5.
  task automatic expect_edge(input logic up, input string tag);
    for (int e = 0; e < 8; e++) begin
      tick();
      check_outs(tag, up ? (e >= 5) : (e < 5), up && (e == 5), !up && (e == 5));
    end
  endtask

  task automatic expect_quiet(input int n, input logic lvl, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check_outs(tag, lvl, 1'b0, 1'b0);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    din     = 1'b0;

    // Reset held with din toggling.
    #1;
    check_outs("rst_init", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      din = ~din;
      tick();
      check_outs("rst_hold", 1'b0, 1'b0, 1'b0);
    end
    din   = 1'b0;
    reset = 1'b1;
    expect_quiet(8, 1'b0, "rst_rel");

    // Clean press then clean release.
    din = 1'b1;
    expect_edge(1'b1, "press");
    din = 1'b0;
    expect_edge(1'b0, "release");

    // Bounce: high 2, low 1, then high and held; count restarts on final rise.
    din = 1'b1;
    expect_quiet(2, 1'b0, "bounce_a");
    din = 1'b0;
    expect_quiet(1, 1'b0, "bounce_b");
    din = 1'b1;
    expect_edge(1'b1, "bounce_press");
    din = 1'b0;
    expect_edge(1'b0, "bounce_rel");

    // Single-cycle glitch while low.
    din = 1'b1;
    tick();
    check_outs("glitch", 1'b0, 1'b0, 1'b0);
    din = 1'b0;
    expect_quiet(8, 1'b0, "glitch_after");

    // Mid-count reset, asserted between edges, then released with din high.
    din = 1'b1;
    expect_quiet(3, 1'b0, "mid_pre");
    #2;
    reset = 1'b0;
    #1;
    check_outs("mid_rst", 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("mid_rst_hold", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    expect_edge(1'b1, "mid_rel");
    din = 1'b0;
    expect_edge(1'b0, "mid_release");

    // Reset in the cycle a rise strobe is high kills it and drops dout at once.
    din = 1'b1;
    for (int e = 0; e < 5; e++) begin
      tick();
      check_outs("kill_pre", 1'b0, 1'b0, 1'b0);
    end
    tick();
    check_outs("kill_rise", 1'b1, 1'b1, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    check_outs("kill_rst", 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("kill_hold", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    expect_edge(1'b1, "kill_rel");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_pulse.md
Name: debounce_pulse

Overview:
- Input-conditioning stage that sits directly upstream of the lab flip-flop/register stages. It cleans a raw, asynchronous, bouncy input (push-button or switch) into a stable level on `dout`, and that level feeds a flip-flop's `d` input.
- It also emits single-cycle `rise` and `fall` strobes, so downstream registers can load or toggle once per physical press.
- Logic: 2-FF synchroniser, then a counter-qualified 4-state FSM.

Parameters:
- STABLE_CYCLES, 1000: consecutive synchronised samples at the new level required before `dout` changes. Legal range is 1 .. 2**CNT_W-1.
- CNT_W, 16: width of the stability counter.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- din  input  1  raw asynchronous input, may bounce.
- dout  output  1  debounced, synchronised level.
- rise  output  1  one-cycle pulse on each accepted 0->1 transition of `dout`.
- fall  output  1  one-cycle pulse on each accepted 1->0 transition of `dout`.

Behaviour:
- Reset (reset=0, asynchronous, immediate, also mid-count):
  - sync1 = sync2 = 0, cnt = 0, state = S_LOW.
  - dout = 0, rise = 0, fall = 0.
- Synchroniser: sync1 <= din, sync2 <= sync1. Only sync2 is used by the FSM.
- FSM states, evaluated on every clk edge using sync2:
  - S_LOW (dout=0):
    - sync2=1 and STABLE_CYCLES=1: go to S_HIGH.
    - sync2=1 otherwise: go to S_WAIT_HIGH with cnt=1.
    - sync2=0: stay, cnt=0.
  - S_WAIT_HIGH (dout=0):
    - sync2=0: go to S_LOW, cnt=0 (glitch rejected, no pulse).
    - sync2=1 and cnt==STABLE_CYCLES-1: go to S_HIGH.
    - sync2=1 otherwise: cnt++.
  - S_HIGH (dout=1): mirror of S_LOW with polarity swapped; leaves to S_WAIT_LOW.
  - S_WAIT_LOW (dout=1): mirror of S_WAIT_HIGH; sync2=1 returns to S_HIGH, completion goes to S_LOW.
- Outputs are registered: dout = (state==S_HIGH || state==S_WAIT_LOW).
- rise is 1 only in the cycle after the edge that enters S_HIGH from S_WAIT_HIGH or S_LOW; fall likewise for entry to S_LOW from S_WAIT_LOW or S_HIGH. rise and fall are never high together.
- Latency: din settles before edge 0. sync2 is new after edge 1. dout, and the matching pulse, change after edge 1+STABLE_CYCLES.
- Bounce rejection: any reversion of sync2 inside a WAIT state resets cnt and returns to the stable state. The count restarts from 1 on the next change, so there is no partial credit.
- Counter never exceeds STABLE_CYCLES-1 and never wraps.
- Reset release with din held high:
  - Treated as a fresh 0->1 transition, with the full latency.
  - rise fires once.
- Reset asserted in any state: outputs drop to 0 immediately, and an in-flight pulse is killed.

Decomposition:
- Package debounce_pkg:
  - typedef enum logic [1:0] state_t {S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW}.
  - Default localparams for STABLE_CYCLES and CNT_W.
- Sub-module sync_2ff (clk, reset, d_async, q_sync): a 2-stage synchroniser, reused for other lab inputs.
- FSM, counter and pulse registers stay in debounce_pulse.

Test Plan (clk period 10, STABLE_CYCLES=4, CNT_W=4):
- Reset check: reset=0 for 20 ns with din toggling -> dout=rise=fall=0 throughout; on reset=1 with din=0, outputs stay 0.
- Clean press: din 0->1 just before edge 0, then held -> dout=1 after edge 5; rise=1 for exactly one cycle after edge 5; fall=0.
- Bounce rejection: din high for 2 cycles, low for 1, then high and held -> no rise during the bounce; dout=1 only 5 edges after the final rise of din (count restarted); exactly one rise.
- Clean release: from dout=1, din 1->0 and held -> dout=0 after edge 5 relative to the change; fall one cycle wide; rise=0.
- Mid-count reset: din high for 3 cycles, then reset=0 for 1 cycle -> outputs 0 at once. After release with din still high, dout rises 5 edges later and rise fires once.
- Short glitch: a 1-cycle din pulse while dout=0 -> dout, rise and fall all remain 0.
